serial_frame_tx: RTL and testbench
==================================

SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 Parameter BIT_CYCLES, default 1, clocks each frame bit is held on ser_out; legal range 1..255.
REQ-002 Parameter PARITY_EN, default 0, 1 inserts an even-parity bit between data and stop bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 par_in  input  8  parallel data word, typically the par_out of the upstream 8-bit shift register.
REQ-006 load  input  1  request to transmit par_in; sampled on the rising edge.
REQ-007 lsb_first  input  1  bit order; 1 = bit 0 first, 0 = bit 7 first; sampled with load.
REQ-008 ser_out  output  1  registered serial line; idle level 1.
REQ-009 ready  output  1  high when a load is accepted this cycle (state IDLE).
REQ-010 busy  output  1  high while a frame is in progress (state not IDLE).
REQ-011 done  output  1  registered one-clock pulse marking frame completion.

Function
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; PARITY is entered only when PARITY_EN=1.
REQ-013 IDLE: ser_out=1, ready=1, busy=0; a rising edge with load=1 captures par_in and lsb_first into internal registers and enters START.
REQ-014 load while busy=1 SHALL be ignored; captured data SHALL NOT change mid-frame.
REQ-015 START drives ser_out=0 for BIT_CYCLES clocks, starting the cycle after the accepting edge.
REQ-016 DATA drives 8 bits, each held BIT_CYCLES clocks, in the order set by captured lsb_first; a 3-bit index counts 0..7.
REQ-017 PARITY drives XOR of the 8 captured bits (even parity) for BIT_CYCLES clocks.
REQ-018 STOP drives ser_out=1 for BIT_CYCLES clocks, then returns to IDLE.
REQ-019 Each bit period SHALL be timed by an 8-bit cycle counter cleared on every state or bit change; no bit period may be shorter or longer than BIT_CYCLES clocks.
REQ-020 Frame length SHALL be exactly (10+PARITY_EN)*BIT_CYCLES clocks from the first START cycle to the last STOP cycle.
REQ-021 done SHALL be high for exactly the first IDLE cycle after STOP, coinciding with ready=1.
REQ-022 load=1 in the done cycle SHALL be accepted; back-to-back frames then have no idle gap beyond that one cycle.
REQ-023 ready SHALL equal NOT busy in every cycle.

Reset
REQ-024 rst=1 SHALL immediately, without a clock edge, force state IDLE, ser_out=1, ready=1, busy=0, done=0, and clear all counters and captured data.
REQ-025 rst asserted mid-frame SHALL abort the frame; no done pulse follows; the first edge after rst deasserts with load=1 starts a fresh frame.
REQ-026 load SHALL be ignored while rst=1.

Verification
REQ-027 BIT_CYCLES=1, PARITY_EN=0, par_in=8'h0F, lsb_first=1, load one cycle -> ser_out 0,1,1,1,1,0,0,0,0,1 on successive cycles; done high in cycle 11; busy high cycles 1-10.
REQ-028 Same with lsb_first=0 -> ser_out 0,0,0,0,0,1,1,1,1,1.
REQ-029 PARITY_EN=1, BIT_CYCLES=1, par_in=8'h07, lsb_first=1 -> 0,1,1,1,0,0,0,0,0,1(parity),1(stop); par_in=8'h0F -> parity bit 0.
REQ-030 BIT_CYCLES=3, par_in=8'h80, lsb_first=1 -> each bit held 3 clocks, 30-clock frame, bit 7 (1) in clocks 25-27.
REQ-031 load held high continuously with par_in changing every cycle -> only values present on accepting edges (IDLE/done cycles) are transmitted; frames separated by one idle cycle.
REQ-032 rst pulsed during DATA bit 3 -> ser_out=1 and busy=0 asynchronously, no done; next load transmits a complete new frame.

Source files
------------

// File: rtl/serial_frame_tx_if.sv
// Purpose: bundles the parallel-load handshake and serial line status of
//          serial_frame_tx into one interface.
// Signals:
//   par_in    8  data word to transmit
//   load      1  transmit request, sampled on the rising clock edge
//   lsb_first 1  bit order for the frame (1 = bit 0 first)
//   ser_out   1  serial line, idles high
//   ready     1  transmitter idle, a load is accepted this cycle
//   busy      1  frame in progress
//   done      1  one-clock pulse on the first idle cycle after a frame
// Modports: master (frame source), slave (the transmitter).
interface serial_frame_tx_if;
  logic [7:0] par_in;
  logic       load;
  logic       lsb_first;
  logic       ser_out;
  logic       ready;
  logic       busy;
  logic       done;

  modport master (
    output par_in, load, lsb_first,
    input  ser_out, ready, busy, done
  );

  modport slave (
    input  par_in, load, lsb_first,
    output ser_out, ready, busy, done
  );
endinterface

// File: rtl/serial_frame_tx.sv
// Purpose: serialises an 8-bit word into a frame of start bit, 8 data bits,
//          optional even-parity bit and stop bit, each bit held BIT_CYCLES
//          clocks.
// Ports:
//   clk  1  clock, rising edge
//   rst  1  asynchronous active-high reset
//   bus     serial_frame_tx_if.slave (par_in, load, lsb_first in;
//           ser_out, ready, busy, done out, all outputs registered)
// Parameters:
//   BIT_CYCLES  clocks per frame bit, 1..255
//   PARITY_EN   1 inserts an even-parity bit before the stop bit
module serial_frame_tx #(
  parameter int unsigned BIT_CYCLES = 1,
  parameter bit          PARITY_EN  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  serial_frame_tx_if.slave bus
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned DAT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DAT_W-1:0]   data_q, data_d;
  logic               lsb_q, lsb_d;

  logic               ser_q, ser_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;

  logic               bit_end;

  // Last clock of the current bit period.
  assign bit_end = (cnt_q == CNT_W'(BIT_CYCLES - 1));

  // State, bit timing and captured-frame registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      lsb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      lsb_q   <= lsb_d;
    end
  end

  // Next-state logic; the cycle counter restarts on every bit or state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    data_d  = data_q;
    lsb_d   = lsb_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.load) begin
          data_d  = bus.par_in;
          lsb_d   = bus.lsb_first;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(7)) begin
            state_d = PARITY_EN ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output lands in a flop
  // aligned with the state it describes.
  always_comb begin
    ser_d   = 1'b1;
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
    done_d  = (state_q == S_STOP) && (state_d == S_IDLE);

    case (state_d)
      S_START:  ser_d = 1'b0;
      S_DATA:   ser_d = lsb_d ? data_d[idx_d] : data_d[IDX_W'(7) - idx_d];
      S_PARITY: ser_d = ^data_d;
      default:  ser_d = 1'b1;
    endcase
  end

  // Output registers; reset forces the idle line level at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ser_q   <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      ser_q   <= ser_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign bus.ser_out = ser_q;
  assign bus.busy    = busy_q;
  assign bus.ready   = ready_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Purpose: scoreboard bench for serial_frame_tx. Three instances cover
//          BIT_CYCLES=1/PARITY_EN=0, BIT_CYCLES=1/PARITY_EN=1 and
//          BIT_CYCLES=3/PARITY_EN=0. Expected frames are written as bit
//          strings in line order (leftmost bit is sent first).
module tb_serial_frame_tx;

  logic       clk;
  logic       rst;
  logic [2:0] load_v;
  logic [2:0] lsb_v;
  logic [7:0] par_v [3];

  logic ser_w   [3];
  logic ready_w [3];
  logic busy_w  [3];
  logic done_w  [3];

  int checks;
  int errors;

  typedef struct {
    int          inst;
    logic [10:0] seq;
    int          nbits;
    int          bc;
  } exp_t;

  exp_t sb_q[$];

  serial_frame_tx_if if0 ();
  serial_frame_tx_if if1 ();
  serial_frame_tx_if if2 ();

  assign if0.par_in = par_v[0];
  assign if0.load = load_v[0];
  assign if0.lsb_first = lsb_v[0];
  assign if1.par_in = par_v[1];
  assign if1.load = load_v[1];
  assign if1.lsb_first = lsb_v[1];
  assign if2.par_in = par_v[2];
  assign if2.load = load_v[2];
  assign if2.lsb_first = lsb_v[2];

  assign ser_w[0] = if0.ser_out;
  assign ser_w[1] = if1.ser_out;
  assign ser_w[2] = if2.ser_out;
  assign ready_w[0] = if0.ready;
  assign ready_w[1] = if1.ready;
  assign ready_w[2] = if2.ready;
  assign busy_w[0] = if0.busy;
  assign busy_w[1] = if1.busy;
  assign busy_w[2] = if2.busy;
  assign done_w[0] = if0.done;
  assign done_w[1] = if1.done;
  assign done_w[2] = if2.done;

  serial_frame_tx #(.BIT_CYCLES(1), .PARITY_EN(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave)
  );
  serial_frame_tx #(.BIT_CYCLES(1), .PARITY_EN(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );
  serial_frame_tx #(.BIT_CYCLES(3), .PARITY_EN(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .bus(if2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: captures ser_out while busy, compares the whole frame on done.
  int          cap_cnt [3];
  logic [63:0] cap     [3];
  int          found;
  exp_t        rec;
  logic [63:0] exp_bits;

  initial begin
    for (int i = 0; i < 3; i++) begin
      cap_cnt[i] = 0;
      cap[i] = '0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("ready_not_busy_%0d", i), 64'(ready_w[i]), 64'(!busy_w[i]));
        if (done_w[i]) begin
          chk($sformatf("done_with_ready_%0d", i), 64'(ready_w[i]), 64'd1);
          found = -1;
          for (int k = 0; k < sb_q.size(); k++) begin
            if (found < 0 && sb_q[k].inst == i) found = k;
          end
          checks++;
          if (found < 0) begin
            errors++;
            $display("FAIL unexpected_done_%0d: got done=1 expected no frame", i);
          end else begin
            rec = sb_q[found];
            sb_q.delete(found);
            exp_bits = '0;
            for (int j = 0; j < rec.nbits * rec.bc; j++) begin
              exp_bits[j] = rec.seq[rec.nbits - 1 - j / rec.bc];
            end
            chk($sformatf("frame_len_%0d", i), 64'(cap_cnt[i]), 64'(rec.nbits * rec.bc));
            chk($sformatf("frame_bits_%0d", i), cap[i], exp_bits);
          end
          cap_cnt[i] = 0;
          cap[i] = '0;
        end else if (busy_w[i]) begin
          if (cap_cnt[i] < 64) cap[i][cap_cnt[i]] = ser_w[i];
          cap_cnt[i]++;
        end else begin
          cap_cnt[i] = 0;
          cap[i] = '0;
        end
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        cap_cnt[i] = 0;
        cap[i] = '0;
      end
    end
  end

  task automatic push_exp(input int i, input logic [10:0] seq, input int nb);
    exp_t e;
    e.inst  = i;
    e.seq   = seq;
    e.nbits = nb;
    e.bc    = (i == 2) ? 3 : 1;
    sb_q.push_back(e);
  endtask

  // Leaves the bench at a falling edge with instance i idle, or flags a timeout.
  task automatic wait_ready(input int i);
    int t;
    t = 0;
    @(negedge clk);
    while (!ready_w[i] && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!ready_w[i]) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout_%0d: got ready=0 expected ready=1 within 500 cycles", i);
    end
  endtask

  task automatic send(input int i, input logic [7:0] d, input logic lsb,
                      input logic [10:0] seq, input int nb, input logic push);
    wait_ready(i);
    if (push) push_exp(i, seq, nb);
    par_v[i]  = d;
    lsb_v[i]  = lsb;
    load_v[i] = 1'b1;
    @(posedge clk);
    #1 load_v[i] = 1'b0;
  endtask

  initial begin
    int t;
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    load_v = '0;
    lsb_v  = '0;
    for (int i = 0; i < 3; i++) par_v[i] = '0;

    #1 rst = 1'b1;
    #2;
    chk("reset_ser_out", 64'(ser_w[0]), 64'd1);
    chk("reset_ready", 64'(ready_w[0]), 64'd1);
    chk("reset_busy", 64'(busy_w[0]), 64'd0);
    chk("reset_done", 64'(done_w[0]), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Basic frames, both bit orders.
    send(0, 8'h0F, 1'b1, 11'b0111100001, 10, 1'b1);
    send(0, 8'h0F, 1'b0, 11'b0000011111, 10, 1'b1);

    // load held high with par_in stepping each cycle: edges 0, 11, 22 accept.
    push_exp(0, 11'b0000001011, 10);
    push_exp(0, 11'b0110101011, 10);
    push_exp(0, 11'b0011011011, 10);
    wait_ready(0);
    lsb_v[0]  = 1'b1;
    par_v[0]  = 8'hA0;
    load_v[0] = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      @(posedge clk);
      #1 par_v[0] = 8'(8'hA0 + k);
    end
    @(posedge clk);
    #1 load_v[0] = 1'b0;

    // Abort a frame during data bit 3 (a 0 bit for 8'h55 sent LSB first).
    send(0, 8'h55, 1'b1, 11'b0, 10, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("busy_before_abort", 64'(busy_w[0]), 64'd1);
    chk("ser_bit3_before_abort", 64'(ser_w[0]), 64'd0);
    rst = 1'b1;
    #1;
    chk("abort_ser_out", 64'(ser_w[0]), 64'd1);
    chk("abort_busy", 64'(busy_w[0]), 64'd0);
    chk("abort_ready", 64'(ready_w[0]), 64'd1);
    chk("abort_done", 64'(done_w[0]), 64'd0);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    // load during reset is ignored; first edge after release starts a frame.
    @(negedge clk);
    rst       = 1'b1;
    par_v[0]  = 8'hFF;
    lsb_v[0]  = 1'b1;
    load_v[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("load_in_reset_busy", 64'(busy_w[0]), 64'd0);
    push_exp(0, 11'b0001111001, 10);
    par_v[0] = 8'h3C;
    lsb_v[0] = 1'b0;
    rst      = 1'b0;
    @(posedge clk);
    #1 load_v[0] = 1'b0;

    // Parity instance.
    send(1, 8'h07, 1'b1, 11'b01110000011, 11, 1'b1);
    send(1, 8'h0F, 1'b1, 11'b01111000001, 11, 1'b1);
    send(1, 8'h81, 1'b0, 11'b01000000101, 11, 1'b1);

    // Three clocks per bit.
    send(2, 8'h80, 1'b1, 11'b0000000011, 10, 1'b1);
    send(2, 8'hA5, 1'b0, 11'b0101001011, 10, 1'b1);

    t = 0;
    while (sb_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
